// File: rtl/code_guess_pkg.sv
// Shared types and constants for the code-guessing game core.
package code_guess_pkg;

  typedef enum logic [2:0] {IDLE, GEN, ENTRY, CMP, WON, LOST} state_e;

  localparam logic [1:0] RES_CORRECT = 2'd0;
  localparam logic [1:0] RES_LOW     = 2'd1;
  localparam logic [1:0] RES_HIGH    = 2'd2;
  localparam logic [1:0] RES_INVALID = 2'd3;

  // Feedback taps 16,14,13,11 expressed as a mask over state bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/code_guess_engine_if.sv
// Guess-entry / result bundle between the game core and its controller.
interface code_guess_engine_if #(
  parameter int DIGITS = 4,
  parameter int DW     = 4,
  parameter int LIVES  = 16
);
  localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                   new_game;
  logic                   digit_valid;
  logic [SEL_W-1:0]       digit_sel;
  logic [DW-1:0]          digit_val;
  logic                   submit;
  logic                   ready;
  logic                   result_valid;
  logic [1:0]             result;
  logic [SEL_W-1:0]       diff_idx;
  logic [DIGITS*DW-1:0]   guess;
  logic [LIVES-1:0]       lives;
  logic                   won;
  logic                   lost;
  logic                   beep_en;

  modport master (
    output new_game, digit_valid, digit_sel, digit_val, submit,
    input  ready, result_valid, result, diff_idx, guess, lives, won, lost, beep_en
  );

  modport slave (
    input  new_game, digit_valid, digit_sel, digit_val, submit,
    output ready, result_valid, result, diff_idx, guess, lives, won, lost, beep_en
  );
endinterface

// File: rtl/code_guess_engine_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; exposes its low OUT_W bits.
module lfsr16
  import code_guess_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [OUT_W-1:0] rnd_o
);
  logic [15:0] state_q, state_d;

  always_comb state_d = {state_q[14:0], ^(state_q & LFSR_TAPS)};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= SEED;
    else         state_q <= state_d;
  end

  assign rnd_o = state_q[OUT_W-1:0];
endmodule

// File: rtl/code_guess_engine.sv
// Game core: target generation, guess entry, MSD-first compare, lives and win/loss.
module code_guess_engine
  import code_guess_pkg::*;
#(
  parameter int                   DIGITS     = 4,
  parameter int                   BASE       = 10,
  parameter int                   DW         = 4,
  parameter int                   LIVES      = 16,
  parameter int                   FIXED_MODE = 0,
  parameter logic [DIGITS*DW-1:0] FIXED_CODE = 16'h6381,
  parameter logic [15:0]          SEED       = 16'hACE1
) (
  input  logic                CLK,
  input  logic                RST,
  code_guess_engine_if.slave  bus
);
  localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(DIGITS - 1);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     k_q, k_d;
  logic                 pend_q, pend_d;
  logic [1:0]           pend_res_q, pend_res_d;
  logic [DIGITS*DW-1:0] target_q, target_d;
  logic [DIGITS*DW-1:0] guess_q, guess_d;
  logic [LIVES-1:0]     lives_q, lives_d;
  logic                 won_q, won_d, lost_q, lost_d;
  logic                 rv_q, rv_d;
  logic [1:0]           res_q, res_d;
  logic [SEL_W-1:0]     diff_q, diff_d;
  logic [DW-1:0]        rnd, g_dig, t_dig;

  lfsr16 #(.SEED(SEED), .OUT_W(DW)) u_lfsr (.clk_i(CLK), .rst_ni(RST), .rnd_o(rnd));

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    pend_d     = pend_q;
    pend_res_d = pend_res_q;
    target_d   = target_q;
    guess_d    = guess_q;
    lives_d    = lives_q;
    won_d      = won_q;
    lost_d     = lost_q;
    rv_d       = 1'b0;
    res_d      = res_q;
    diff_d     = diff_q;
    g_dig      = guess_q[(DIGITS-1-int'(k_q))*DW +: DW];
    t_dig      = target_q[(DIGITS-1-int'(k_q))*DW +: DW];

    if (bus.new_game) begin
      state_d = GEN;
      k_d     = '0;
      pend_d  = 1'b0;
      guess_d = '0;
      lives_d = '1;
      won_d   = 1'b0;
      lost_d  = 1'b0;
    end else begin
      unique case (state_q)
        GEN: begin
          if (FIXED_MODE != 0) begin
            target_d = FIXED_CODE;
            state_d  = ENTRY;
          end else if (int'(rnd) < BASE) begin
            target_d[(DIGITS-1-int'(k_q))*DW +: DW] = rnd;
            if (k_q == LAST) state_d = ENTRY;
            else             k_d = k_q + 1'b1;
          end
        end
        ENTRY: begin
          // Write lands before a same-cycle submit so CMP sees the new digit
          if (bus.digit_valid) begin
            if (int'(bus.digit_val) < BASE && int'(bus.digit_sel) < DIGITS)
              guess_d[(DIGITS-1-int'(bus.digit_sel))*DW +: DW] = bus.digit_val;
            else begin
              rv_d   = 1'b1;
              res_d  = RES_INVALID;
              diff_d = '0;
            end
          end
          if (bus.submit) begin
            state_d = CMP;
            k_d     = '0;
            pend_d  = 1'b0;
          end
        end
        CMP: begin
          if (!pend_q) begin
            pend_d = 1'b1;
            if (g_dig < t_dig)      pend_res_d = RES_LOW;
            else if (g_dig > t_dig) pend_res_d = RES_HIGH;
            else if (k_q == LAST)   pend_res_d = RES_CORRECT;
            else begin
              pend_d = 1'b0;
              k_d    = k_q + 1'b1;
            end
          end else begin
            // Decision was taken last cycle; publish it and settle the game
            pend_d = 1'b0;
            rv_d   = 1'b1;
            res_d  = pend_res_q;
            diff_d = (pend_res_q == RES_CORRECT) ? '0 : k_q;
            if (pend_res_q == RES_CORRECT) begin
              won_d   = 1'b1;
              state_d = WON;
            end else begin
              lives_d = lives_q << 1;
              if (lives_d == '0) begin
                lost_d  = 1'b1;
                state_d = LOST;
              end else begin
                state_d = ENTRY;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      k_q        <= '0;
      pend_q     <= 1'b0;
      pend_res_q <= RES_CORRECT;
      target_q   <= '0;
      guess_q    <= '0;
      lives_q    <= '1;
      won_q      <= 1'b0;
      lost_q     <= 1'b0;
      rv_q       <= 1'b0;
      res_q      <= RES_CORRECT;
      diff_q     <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      pend_q     <= pend_d;
      pend_res_q <= pend_res_d;
      target_q   <= target_d;
      guess_q    <= guess_d;
      lives_q    <= lives_d;
      won_q      <= won_d;
      lost_q     <= lost_d;
      rv_q       <= rv_d;
      res_q      <= res_d;
      diff_q     <= diff_d;
    end
  end

  assign bus.ready        = (state_q == ENTRY);
  assign bus.result_valid = rv_q;
  assign bus.result       = res_q;
  assign bus.diff_idx     = diff_q;
  assign bus.guess        = guess_q;
  assign bus.lives        = lives_q;
  assign bus.won          = won_q;
  assign bus.lost         = lost_q;
  assign bus.beep_en      = won_q;
endmodule
